ram_bus_controller: RTL and testbench

- Request/response front end that sits directly upstream of the banked single-port synchronous RAM.
- Converts a valid/ready request channel into RAM bus cycles: `addr`, `cs`, `we`, `oe`, and the shared bidirectional `data` bus.
- Owns the tristate data bus, sequences the RAM's registered-read latency, and returns read data on a held response channel.
- Sole master of the RAM bus; one transaction in flight.

---
 rtl/ram_bus_controller_pkg.sv | 29 ++
 rtl/ram_bus_controller_tristate_drv.sv | 16 +
 rtl/ram_bus_controller.sv | 147 ++++++++++++++
 tb/tb_ram_bus_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_controller_pkg.sv
// ram_ctrl_pkg: shared types and limits for the RAM bus controller.
//   ctrl_state_t   - controller FSM state encoding
//   MAX_RD_LATENCY - largest supported RAM read latency (clock edges)
//   lat_width      - width needed for the read-latency down-counter
package ram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_WAIT = 3'd2,
        RD_CAP  = 3'd3,
        RSP     = 3'd4
    } ctrl_state_t;

    localparam int MAX_RD_LATENCY = 4;

    // Width of the latency counter; never below one bit.
    function automatic int lat_width(input int max_lat);
        int w;
        w = $clog2(max_lat);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_bus_controller_tristate_drv.sv
// tristate_drv: the single point where the controller drives the shared RAM
// data bus. When en is low the pad is released (high-Z).
//   en   - drive enable
//   din  - value placed on the pad while enabled
//   pad  - bidirectional bus pin
module tristate_drv #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    inout  wire  [DATA_WIDTH-1:0] pad
);

    assign pad = en ? din : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram_bus_controller.sv
// ram_bus_controller: valid/ready request front end for a banked single-port
// synchronous RAM. Turns one request at a time into RAM bus cycles, owns the
// tristate data bus, waits out the RAM's registered-read latency and returns
// read data on a held response channel.
//   clk, rst                         - clock, asynchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata               - request channel
//   rsp_valid/rsp_ready/rsp_rdata    - read response channel (held until taken)
//   mem_addr/mem_data/mem_cs/
//   mem_we/mem_oe                    - RAM bus (mem_data bidirectional)
//   busy                             - controller not idle
module ram_bus_controller
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  busy
);

    localparam int LAT_W = lat_width(MAX_RD_LATENCY);

    if ((RD_LATENCY < 1) || (RD_LATENCY > MAX_RD_LATENCY)) begin : g_bad_latency
        $error("ram_bus_controller: RD_LATENCY must be within 1..%0d", MAX_RD_LATENCY);
    end

    ctrl_state_t           state_r;
    logic [LAT_W-1:0]      lat_cnt_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  drv_en_r;
    logic                  accept_s;

    // req_ready is a decode of the state register, forced low during reset.
    assign req_ready = (state_r == IDLE) & ~rst;
    assign busy      = (state_r != IDLE);
    assign accept_s  = req_valid & req_ready;

    // The captured request address feeds the RAM directly; no arithmetic on it.
    assign mem_addr = addr_r;

    tristate_drv #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_bus_drv (
        .en  (drv_en_r),
        .din (wdata_r),
        .pad (mem_data)
    );

    // Controller FSM: every RAM control is set for the state being entered,
    // so mem_* outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            lat_cnt_r <= {LAT_W{1'b0}};
            addr_r    <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {DATA_WIDTH{1'b0}};
            drv_en_r  <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        mem_cs  <= 1'b1;
                        if (req_we) begin
                            state_r  <= WRITE;
                            mem_we   <= 1'b1;
                            mem_oe   <= 1'b0;
                            drv_en_r <= 1'b1;
                        end else begin
                            state_r   <= RD_WAIT;
                            lat_cnt_r <= LAT_W'(RD_LATENCY - 1);
                            mem_we    <= 1'b0;
                            mem_oe    <= 1'b1;
                            drv_en_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    // The RAM latches the write at this closing edge.
                    state_r  <= IDLE;
                    mem_cs   <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_oe   <= 1'b0;
                    drv_en_r <= 1'b0;
                end
                RD_WAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        state_r <= RD_CAP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                end
                RD_CAP: begin
                    // RAM data is valid on the bus now; release the bus as we
                    // enter RSP so the turnaround cycle has oe low.
                    rsp_rdata <= mem_data;
                    rsp_valid <= 1'b1;
                    mem_cs    <= 1'b0;
                    mem_oe    <= 1'b0;
                    state_r   <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= RSP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    drv_en_r  <= 1'b0;
                    mem_cs    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_oe    <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_controller.sv
module tb_ram_bus_controller;

    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ref_mem [256];

    always #5 clk = ~clk;

    ram_bus_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_LATENCY(RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .busy      (busy)
    );

    // Behavioural RAM: writes on cs&we, read data appears RD_LAT edges after
    // the read address is presented and is driven only while oe is high.
    logic [DW-1:0] ram [256];
    logic          vld_pipe [RD_LAT];
    logic          ram_drive_s;

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
        for (int i = RD_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
        vld_pipe[0] <= mem_cs & mem_oe & ~mem_we;
    end

    assign ram_drive_s = vld_pipe[RD_LAT-1] & mem_cs & mem_oe & ~mem_we;
    assign mem_data    = ram_drive_s ? ram[mem_addr] : {DW{1'bz}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus ownership monitor: controller drives only in a write cycle, and
    // never while the RAM is driving.
    always @(negedge clk) begin
        if (dut.drv_en_r) chk("drive_implies_write", {29'd0, mem_cs, mem_we, mem_oe}, 32'h6);
        if (ram_drive_s)  chk("bus_contention", {31'd0, dut.drv_en_r}, 32'h0);
    end

    task automatic present_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("req_ready_timeout", {31'd0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        present_req(1'b1, a, d);
        ref_mem[a] = d;
        @(negedge clk);
        chk("wr_cs", {31'd0, mem_cs}, 32'h1);
        chk("wr_we", {31'd0, mem_we}, 32'h1);
        chk("wr_oe", {31'd0, mem_oe}, 32'h0);
        chk("wr_addr", {24'd0, mem_addr}, {24'd0, a});
        chk("wr_bus", {24'd0, mem_data}, {24'd0, d});
        @(posedge clk);
        #1;
        chk("wr_back_idle", {30'd0, busy, mem_we}, 32'h0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold);
        int n;
        logic [DW-1:0] e;
        present_req(1'b0, a, 8'h00);
        exp_q.push_back(ref_mem[a]);
        rsp_ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!rsp_valid && n < 16);
        chk("rd_latency", n, RD_LAT + 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_data", {24'd0, rsp_rdata}, {24'd0, e});
        end else begin
            e = 8'h00;
            chk("scoreboard_empty", 32'd0, 32'd1);
        end
        chk("rsp_turnaround", {30'd0, mem_oe, dut.drv_en_r}, 32'h0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'h1);
            chk("hold_data", {24'd0, rsp_rdata}, {24'd0, e});
            chk("hold_ready_low", {31'd0, req_ready}, 32'h0);
            // Stray write request while busy must be ignored.
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = a;
            req_wdata = 8'h00;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("rsp_released", {30'd0, rsp_valid, busy}, 32'h0);
        chk("rsp_retained", {24'd0, rsp_rdata}, {24'd0, e});
        chk("idle_oe_low", {30'd0, mem_oe, dut.drv_en_r}, 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        #1;
        chk("rst_ctrl", {29'd0, mem_cs, mem_we, mem_oe}, 32'h0);
        chk("rst_addr", {24'd0, mem_addr}, 32'h0);
        chk("rst_rsp", {23'd0, rsp_valid, rsp_rdata}, 32'h0);
        chk("rst_busy_ready", {30'd0, busy, req_ready}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Write then read
        do_write(8'h13, 8'h5A);
        do_read(8'h13, 0);

        // All four banks, read back in reverse, plus all-ones address
        do_write(8'h05, 8'h11);
        do_write(8'h45, 8'h22);
        do_write(8'h85, 8'h33);
        do_write(8'hC5, 8'h44);
        do_read(8'hC5, 0);
        do_read(8'h85, 0);
        do_read(8'h45, 0);
        do_read(8'h05, 0);
        do_write(8'hFF, 8'hA5);
        do_read(8'hFF, 0);

        // Response backpressure with ignored requests
        do_read(8'h13, 5);

        // Read immediately followed by write (turnaround), then check it
        do_read(8'h13, 0);
        do_write(8'h20, 8'h77);
        do_read(8'h20, 0);

        // Reset in the middle of a read
        present_req(1'b0, 8'h45, 8'h00);
        #2 rst = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h13;
        req_wdata = 8'h00;
        #1;
        chk("midrd_rst_ctrl", {30'd0, mem_cs, mem_oe}, 32'h0);
        chk("midrd_rst_rsp", {29'd0, rsp_valid, busy, req_ready}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_no_accept", {30'd0, busy, req_ready}, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;
        repeat (RD_LAT + 1) @(posedge clk);
        do_read(8'h13, 0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
